// File: rtl/hpu_axil_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | hpu_axil_pkg : shared AXI-Lite response codes, register map and FSM states
// | Revision     : 1.0
// +-----------------------------------------------------------------------------
package hpu_axil_pkg;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
   localparam logic [31:0] REG_CONTROL = 32'h0000_0010;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_WADDR = 3'd1;
   localparam state_t ST_WRESP = 3'd2;
   localparam state_t ST_RADDR = 3'd3;
   localparam state_t ST_RDATA = 3'd4;
   localparam state_t ST_RSP   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/axil_cfg_master_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | axil_cfg_master_if : AXI4-Lite bus between config master and register slave
// | Revision           : 1.0
// +-----------------------------------------------------------------------------
interface axil_cfg_master_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axil_cfg_master_timeout_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | axil_timeout_cnt : saturating phase counter, one-cycle expired pulse
// | Revision         : 1.0
// +-----------------------------------------------------------------------------
module axil_timeout_cnt #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int             CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  C_MAX  = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   // Saturating at TIMEOUT keeps the expired pulse to a single cycle per phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = enable && !clear && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/axil_cfg_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | axil_cfg_master : single-outstanding AXI4-Lite master for register commands
// | Revision        : 1.0
// +-----------------------------------------------------------------------------
module axil_cfg_master
   import hpu_axil_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_we,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              timeout,
   axil_cfg_master_if.master m_axi
);
   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
   logic              r_aw_done, r_w_done;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_rsp_valid, r_rsp_we;
   logic [31:0]       r_rsp_rdata;
   logic [1:0]        r_rsp_resp;
   logic              r_timeout;

   logic w_aw_fin, w_w_fin, w_leave, w_wait, w_expired;

   assign w_aw_fin = r_aw_done || (r_awvalid && m_axi.awready);
   assign w_w_fin  = r_w_done  || (r_wvalid  && m_axi.wready);

   // w_leave marks the cycle the state register will change
   always_comb begin
      w_leave = 1'b0;
      case (r_state)
         ST_IDLE:  w_leave = cmd_valid && r_cmd_ready;
         ST_WADDR: w_leave = w_aw_fin && w_w_fin;
         ST_WRESP: w_leave = m_axi.bvalid && r_bready;
         ST_RADDR: w_leave = r_arvalid && m_axi.arready;
         ST_RDATA: w_leave = m_axi.rvalid && r_rready;
         ST_RSP:   w_leave = rsp_ready;
         default:  w_leave = 1'b1;
      endcase
   end

   assign w_wait = (r_state == ST_WADDR) || (r_state == ST_WRESP) ||
                   (r_state == ST_RADDR) || (r_state == ST_RDATA);

   axil_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_leave),
      .enable  (w_wait),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (w_expired) r_timeout <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_leave) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  r_wstrb     <= cmd_wstrb;
                  r_aw_done   <= 1'b0;
                  r_w_done    <= 1'b0;
                  if (cmd_we) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WADDR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RADDR;
                  end
               end
            end
            ST_WADDR: begin
               if (r_awvalid && m_axi.awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid && m_axi.wready) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_leave) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WRESP;
               end
            end
            ST_WRESP: begin
               if (w_leave) begin
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_resp  <= m_axi.bresp;
                  r_state     <= ST_RSP;
               end
            end
            ST_RADDR: begin
               if (w_leave) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (w_leave) begin
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= 1'b0;
                  r_rsp_rdata <= m_axi.rdata;
                  r_rsp_resp  <= m_axi.rresp;
                  r_state     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (w_leave) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_we        = r_rsp_we;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign timeout       = r_timeout;

   assign m_axi.awaddr  = r_addr;
   assign m_axi.awvalid = r_awvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.bready  = r_bready;
   assign m_axi.araddr  = r_addr;
   assign m_axi.arvalid = r_arvalid;
   assign m_axi.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_cfg_master.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_axil_cfg_master : directed bench with a delay-programmable register slave
// | Revision           : 1.0
// +-----------------------------------------------------------------------------
module tb_axil_cfg_master;
   import hpu_axil_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_we, rsp_ready;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        cmd_ready, rsp_valid, rsp_we, timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axil_cfg_master_if #(.ADDR_W(32)) axi ();

   axil_cfg_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .timeout   (timeout),
      .m_axi     (axi)
   );

   always #5 clk = ~clk;

   // ---------------- register slave with programmable ready/valid delays
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
   bit          aw_never = 0, ar_never = 0;
   int          aw_cnt, w_cnt, ar_cnt, r_cnt;
   logic        aw_got, w_got, r_pend;
   logic [31:0] s_awaddr, s_wdata, s_araddr, reg_ctl;
   logic [3:0]  s_wstrb;
   logic [1:0]  reg_run;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         axi.awready <= 0; axi.wready <= 0; axi.bvalid <= 0; axi.bresp <= 0;
         axi.arready <= 0; axi.rvalid <= 0; axi.rdata <= 0; axi.rresp <= 0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         aw_got <= 0; w_got <= 0; r_pend <= 0;
         s_awaddr <= 0; s_wdata <= 0; s_wstrb <= 0; s_araddr <= 0;
         reg_ctl <= 0; reg_run <= 0;
      end else begin
         if (axi.awvalid && axi.awready) begin
            axi.awready <= 0; aw_got <= 1; s_awaddr <= axi.awaddr; aw_cnt <= 0;
         end else if (axi.awvalid && !aw_got && !aw_never) begin
            if (aw_cnt >= aw_delay) axi.awready <= 1; else aw_cnt <= aw_cnt + 1;
         end
         if (axi.wvalid && axi.wready) begin
            axi.wready <= 0; w_got <= 1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; w_cnt <= 0;
         end else if (axi.wvalid && !w_got) begin
            if (w_cnt >= w_delay) axi.wready <= 1; else w_cnt <= w_cnt + 1;
         end
         if (axi.bvalid && axi.bready) begin
            axi.bvalid <= 0; aw_got <= 0; w_got <= 0;
         end else if (aw_got && w_got && !axi.bvalid) begin
            axi.bvalid <= 1;
            axi.bresp  <= RESP_OKAY;
            if (s_awaddr == REG_CTRL) begin
               if (s_wstrb[0]) reg_run <= s_wdata[1:0];
            end else if (s_awaddr == REG_CONTROL) begin
               for (int i = 0; i < 4; i++)
                  if (s_wstrb[i]) reg_ctl[8*i +: 8] <= s_wdata[8*i +: 8];
            end else begin
               axi.bresp <= RESP_SLVERR;
            end
         end
         if (axi.arvalid && axi.arready) begin
            axi.arready <= 0; r_pend <= 1; s_araddr <= axi.araddr; ar_cnt <= 0; r_cnt <= 0;
         end else if (axi.arvalid && !r_pend && !ar_never) begin
            if (ar_cnt >= ar_delay) axi.arready <= 1; else ar_cnt <= ar_cnt + 1;
         end
         if (axi.rvalid && axi.rready) begin
            axi.rvalid <= 0; r_pend <= 0;
         end else if (r_pend && !axi.rvalid) begin
            if (r_cnt >= r_delay) begin
               axi.rvalid <= 1;
               axi.rresp  <= RESP_OKAY;
               if (s_araddr == REG_CTRL)         axi.rdata <= {30'd0, reg_run};
               else if (s_araddr == REG_CONTROL) axi.rdata <= reg_ctl;
               else begin axi.rdata <= 0; axi.rresp <= RESP_SLVERR; end
            end else begin
               r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // ---------------- bus activity monitors
   int n_bhs = 0, n_act = 0, n_wfirst = 0, n_rwait = 0;
   always @(posedge clk) begin
      if (axi.bvalid && axi.bready) n_bhs++;
      if (axi.awvalid || axi.wvalid || axi.arvalid || axi.bready || axi.rready) n_act++;
   end
   always @(negedge clk) begin
      if (axi.awvalid && !axi.wvalid) n_wfirst++;
      if (axi.rready && !axi.rvalid)  n_rwait++;
   end

   // ---------------- checking helpers
   int n_pass = 0, n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      int k = 0;
      while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
      chk("cmd_ready_before_issue", cmd_ready, 1);
      cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_rsp();
      int k = 0;
      while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
      chk("rsp_valid_within_bound", rsp_valid, 1);
   endtask

   task automatic consume();
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   int b0, w0, rw0, a0;

   initial begin
      rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {cmd_ready, rsp_valid, rsp_we, timeout, axi.awvalid, axi.wvalid,
           axi.bready, axi.arvalid, axi.rready}, 0);
      chk("reset_rsp_data", {rsp_rdata, rsp_resp}, 0);
      rst = 0;
      chk("cmd_ready_low_before_first_edge", cmd_ready, 0);
      @(negedge clk);
      chk("cmd_ready_after_release", cmd_ready, 1);

      // 1: write run/gen, AW and W accepted together
      issue(1, REG_CTRL, 32'h3, 4'hF);
      chk("t1_aw_w_valid_next_cycle", {axi.awvalid, axi.wvalid, cmd_ready}, 3'b110);
      wait_rsp();
      chk("t1_rsp", {rsp_we, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
      consume();
      chk("t1_slave_run_gen", reg_run, 2'b11);
      chk("t1_back_to_idle", {cmd_ready, rsp_valid}, 2'b10);

      // 2: W accepted 3 cycles ahead of AW
      aw_delay = 3; b0 = n_bhs; w0 = n_wfirst;
      issue(1, REG_CONTROL, 32'hDEADBEEF, 4'hF);
      wait_rsp();
      chk("t2_rsp", {rsp_we, rsp_resp}, 3'b100);
      consume();
      chk("t2_single_b", n_bhs - b0, 1);
      chk("t2_wvalid_dropped_first_cycles", n_wfirst - w0, 3);
      aw_delay = 0;
      issue(0, REG_CONTROL, 0, 0);
      chk("t2_arvalid_next_cycle", axi.arvalid, 1);
      wait_rsp();
      chk("t2_readback", {rsp_we, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'hDEADBEEF});
      consume();

      // 3: read with RVALID delayed
      r_delay = 5; rw0 = n_rwait;
      issue(0, REG_CTRL, 0, 0);
      wait_rsp();
      chk("t3_rdata_run_gen", {rsp_resp, rsp_rdata}, {2'b00, 32'h3});
      chk("t3_rready_held", n_rwait - rw0, 6);
      consume();
      r_delay = 0;

      // 4: response back-pressure, and a pending command must not be taken
      issue(1, REG_CONTROL, 32'h1234_5678, 4'b0011);
      wait_rsp();
      a0 = n_act;
      cmd_we = 0; cmd_addr = REG_CTRL; cmd_valid = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_hold_rsp_valid_cmd_ready", {rsp_valid, cmd_ready}, 2'b10);
      end
      cmd_valid = 0;
      chk("t4_no_axi_activity", n_act - a0, 0);
      consume();
      issue(0, REG_CONTROL, 0, 0);
      wait_rsp();
      chk("t4_strobed_write", rsp_rdata, 32'hDEAD_5678);
      consume();

      // non-OKAY response passes through
      issue(1, 32'h0000_0020, 32'h1, 4'hF);
      wait_rsp();
      chk("slverr_passthrough", rsp_resp, RESP_SLVERR);
      consume();

      // 5: AWREADY withheld, TIMEOUT=16
      aw_never = 1;
      issue(1, REG_CONTROL, 32'hA5A5A5A5, 4'hF);
      repeat (15) @(negedge clk);
      chk("t5_timeout_not_yet", timeout, 0);
      @(negedge clk);
      chk("t5_timeout_set", {timeout, axi.awvalid, axi.wvalid}, 3'b110);
      aw_never = 0;
      wait_rsp();
      chk("t5_completes_okay", rsp_resp, RESP_OKAY);
      consume();
      chk("t5_timeout_sticky", timeout, 1);

      // 6: reset while ARVALID is high
      ar_never = 1;
      issue(0, REG_CONTROL, 0, 0);
      chk("t6_arvalid_before_rst", axi.arvalid, 1);
      #2 rst = 1;
      #1 chk("t6_async_reset", {axi.arvalid, cmd_ready, timeout, rsp_valid}, 0);
      @(negedge clk);
      rst = 0; ar_never = 0;
      chk("t6_cmd_ready_in_reset_window", cmd_ready, 0);
      @(negedge clk);
      chk("t6_cmd_ready_after_release", cmd_ready, 1);
      issue(0, REG_CONTROL, 0, 0);
      wait_rsp();
      chk("t6_read_after_reset", {rsp_resp, rsp_rdata, timeout}, {2'b00, 32'h0, 1'b0});
      consume();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
